edge_to_ard_link: RTL and testbench

EDGE_TO_ARD_LINK -- requirements
Module: edge_to_ard_link

---
 rtl/edge_to_ard_link_if.sv | 12 +
 rtl/edge_to_ard_link.sv | 111 +++++++++++
 tb/tb_edge_to_ard_link.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_to_ard_link_if.sv
// Request/serial bundle between the edge status logic and the Arduino UART link.
// master = requester (drives payload/start), slave = link (drives tx/busy/done).
interface edge_to_ard_link_if;
    logic [39:0] payload;
    logic        start;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output payload, output start, input tx, input busy, input done);
    modport slave  (input payload, input start, output tx, output busy, output done);
endinterface

// File: rtl/edge_to_ard_link.sv
// Sends a 40-bit status word to an Arduino as ten Hamming(8,4)-coded bytes over 8N1 UART.
// tx/busy/done are decoded straight from the state so an async reset forces the line idle at once.
module edge_to_ard_link #(
    parameter int CLKFRQ   = 100000000,
    parameter int BAUDRATE = 9600
) (
    input  logic              clk,
    input  logic              reset,
    edge_to_ard_link_if.slave bus
);
    localparam int            BITCYC    = CLKFRQ / BAUDRATE;
    localparam int            CW        = (BITCYC > 1) ? $clog2(BITCYC) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(BITCYC - 1);
    localparam logic [3:0]    LAST_BYTE = 4'd9;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [3:0]    r_byte;
    logic [39:0]   r_payload;

    logic          w_bit_end;
    logic [5:0]    w_off;
    logic [3:0]    w_nib;
    logic [7:0]    w_code;

    // Byte layout {P, d4, d3, d2, p3, d1, p2, p1}, P = even parity over the lower seven bits.
    function automatic logic [7:0] hamming_enc(input logic [3:0] nib);
        logic [6:0] h;
        h[0] = nib[0] ^ nib[1] ^ nib[3];
        h[1] = nib[0] ^ nib[2] ^ nib[3];
        h[2] = nib[0];
        h[3] = nib[1] ^ nib[2] ^ nib[3];
        h[4] = nib[1];
        h[5] = nib[2];
        h[6] = nib[3];
        return {^h, h};
    endfunction

    assign w_bit_end = (r_cnt == CNT_MAX);
    assign w_off     = {r_byte, 2'b00};
    assign w_nib     = r_payload[w_off +: 4];
    assign w_code    = hamming_enc(w_nib);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_payload <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.start) begin
                        r_payload <= bus.payload;
                        r_byte    <= '0;
                        r_bit     <= '0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) r_state <= STOP;
                        else               r_bit   <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // Next byte's start bit follows the stop bit with no gap.
                        if (r_byte < LAST_BYTE) begin
                            r_byte  <= r_byte + 1'b1;
                            r_state <= START;
                        end else begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx   = (r_state == START) ? 1'b0 :
                      (r_state == DATA)  ? w_code[r_bit] : 1'b1;
    assign bus.busy = (r_state == START) || (r_state == DATA) || (r_state == STOP);
    assign bus.done = (r_state == DONE);
endmodule

// File: tb/tb_edge_to_ard_link.sv
// Directed bench for edge_to_ard_link at BITCYC=16: frame content, timing, start filtering, reset abort.
module tb_edge_to_ard_link;
    logic clk;
    logic reset;
    edge_to_ard_link_if u_if ();

    edge_to_ard_link #(.CLKFRQ(16), .BAUDRATE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx [10];
    int         busy_cnt, done_cnt, frame_err, to;
    logic       done_at_end, first_tx;

    // Hand-computed code table for each nibble.
    function automatic logic [7:0] tb_code(input logic [3:0] n);
        case (n)
            4'h0: return 8'h00;  4'h1: return 8'h87;  4'h2: return 8'h99;  4'h3: return 8'h1E;
            4'h4: return 8'hAA;  4'h5: return 8'h2D;  4'h6: return 8'h33;  4'h7: return 8'hB4;
            4'h8: return 8'h4B;  4'h9: return 8'hCC;  4'hA: return 8'hD2;  4'hB: return 8'h55;
            4'hC: return 8'hE1;  4'hD: return 8'h66;  4'hE: return 8'h78;  default: return 8'hFF;
        endcase
    endfunction

    // Reference decoder: {error_flag, nibble}.
    function automatic logic [4:0] tb_dec(input logic [7:0] c);
        logic s1, s2, s3;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s3 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s1 | s2 | s3 | (^c), c[6], c[5], c[4], c[2]};
    endfunction

    task automatic pulse_start();
        @(negedge clk); u_if.start = 1'b1;
        @(negedge clk); u_if.start = 1'b0;
    endtask

    // Samples one frame mid-bit starting on its first busy cycle, plus the DONE and IDLE cycles after it.
    task automatic capture();
        int w;
        w = 0; to = 0; busy_cnt = 0; done_cnt = 0; frame_err = 0; done_at_end = 1'b0; first_tx = 1'b1;
        while (u_if.busy !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        if (u_if.busy !== 1'b1) begin to = 1; return; end
        first_tx = u_if.tx;
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < 10; k++)
                for (int c = 0; c < 16; c++) begin
                    if (u_if.busy === 1'b1) busy_cnt++;
                    if (u_if.done === 1'b1) done_cnt++;
                    if (c == 8) begin
                        if (k == 0) begin
                            if (u_if.tx !== 1'b0) frame_err++;
                        end else if (k == 9) begin
                            if (u_if.tx !== 1'b1) frame_err++;
                        end else begin
                            rx[b][k-1] = u_if.tx;
                        end
                    end
                    @(negedge clk);
                end
        done_at_end = u_if.done;
        for (int i = 0; i < 2; i++) begin
            if (u_if.busy === 1'b1) busy_cnt++;
            if (u_if.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; u_if.start = 1'b0; u_if.payload = '0;
        repeat (3) @(negedge clk);
        checks++; if (u_if.tx !== 1'b1)   begin errors++; $display("FAIL reset_tx got %b want 1", u_if.tx); end
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
        checks++; if (u_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", u_if.done); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (u_if.tx !== 1'b1) begin errors++; $display("FAIL idle_tx got %b want 1", u_if.tx); end
    endtask

    task automatic test_zero_frame();
        u_if.payload = 40'h0;
        pulse_start();
        capture();
        checks++; if (to != 0) begin errors++; $display("FAIL zero_timeout busy never rose"); end
        checks++; if (first_tx !== 1'b0) begin errors++; $display("FAIL zero_first_tx got %b want 0", first_tx); end
        for (int b = 0; b < 10; b++) begin
            checks++; if (rx[b] !== 8'h00) begin errors++; $display("FAIL zero_byte%0d got %h want 00", b, rx[b]); end
        end
        checks++; if (busy_cnt != 1600) begin errors++; $display("FAIL zero_busy_len got %0d want 1600", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
        checks++; if (done_at_end !== 1'b1) begin errors++; $display("FAIL zero_done_pos got %b want 1", done_at_end); end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL zero_framing got %0d want 0", frame_err); end
    endtask

    task automatic test_patterns();
        u_if.payload = 40'hFFFFFFFFFF;
        pulse_start();
        capture();
        checks++; if (to != 0) begin errors++; $display("FAIL ones_timeout busy never rose"); end
        for (int b = 0; b < 10; b++) begin
            checks++; if (rx[b] !== 8'hFF) begin errors++; $display("FAIL ones_byte%0d got %h want ff", b, rx[b]); end
        end
        checks++; if (frame_err != 0) begin errors++; $display("FAIL ones_framing got %0d want 0", frame_err); end

        u_if.payload = 40'h0000000001;
        pulse_start();
        capture();
        checks++; if (rx[0] !== 8'h87) begin errors++; $display("FAIL one_byte0 got %h want 87", rx[0]); end
        for (int b = 1; b < 10; b++) begin
            checks++; if (rx[b] !== 8'h00) begin errors++; $display("FAIL one_byte%0d got %h want 00", b, rx[b]); end
        end
        checks++; if (busy_cnt != 1600) begin errors++; $display("FAIL one_busy_len got %0d want 1600", busy_cnt); end
    endtask

    task automatic test_mixed();
        logic [39:0] pl, dec;
        int          derr;
        pl = 40'h0123456789; dec = '0; derr = 0;
        u_if.payload = pl;
        pulse_start();
        capture();
        for (int b = 0; b < 10; b++) begin
            logic [4:0] d;
            checks++;
            if (rx[b] !== tb_code(pl[4*b +: 4])) begin
                errors++; $display("FAIL mixed_byte%0d got %h want %h", b, rx[b], tb_code(pl[4*b +: 4]));
            end
            d = tb_dec(rx[b]);
            dec[4*b +: 4] = d[3:0];
            if (d[4]) derr++;
        end
        checks++; if (dec !== pl) begin errors++; $display("FAIL mixed_decode got %h want %h", dec, pl); end
        checks++; if (derr != 0) begin errors++; $display("FAIL mixed_syndrome got %0d want 0", derr); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mixed_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_ignore_start();
        logic [39:0] pl;
        int          extra_busy;
        pl = 40'h0123456789; extra_busy = 0;
        u_if.payload = pl;
        pulse_start();
        fork
            capture();
            begin
                repeat (4) @(negedge clk);
                u_if.start = 1'b1; @(negedge clk); u_if.start = 1'b0;
                u_if.payload = 40'hFEDCBA9876;
                repeat (794) @(negedge clk);
                u_if.start = 1'b1; @(negedge clk); u_if.start = 1'b0;
            end
        join
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (rx[b] !== tb_code(pl[4*b +: 4])) begin
                errors++; $display("FAIL ign_byte%0d got %h want %h", b, rx[b], tb_code(pl[4*b +: 4]));
            end
        end
        checks++; if (busy_cnt != 1600) begin errors++; $display("FAIL ign_busy_len got %0d want 1600", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt); end
        for (int i = 0; i < 20; i++) begin
            if (u_if.busy !== 1'b0) extra_busy++;
            @(negedge clk);
        end
        checks++; if (extra_busy != 0) begin errors++; $display("FAIL ign_restart busy cycles %0d want 0", extra_busy); end
        u_if.payload = 40'h0;
    endtask

    task automatic test_reset_mid();
        int dcnt, bcnt;
        dcnt = 0; bcnt = 0;
        u_if.payload = 40'h0;
        pulse_start();
        repeat (700) @(negedge clk);
        checks++; if (u_if.tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx got %b want 0", u_if.tx); end
        #2 reset = 1'b1;
        #1;
        checks++; if (u_if.tx !== 1'b1)   begin errors++; $display("FAIL rst_tx got %b want 1", u_if.tx); end
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", u_if.busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (u_if.done === 1'b1) dcnt++;
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (u_if.done === 1'b1) dcnt++;
            if (u_if.busy === 1'b1) bcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", dcnt); end
        checks++; if (bcnt != 0) begin errors++; $display("FAIL rst_idle_busy got %0d want 0", bcnt); end
        u_if.payload = 40'hA5C3E1B7D9;
        pulse_start();
        capture();
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (rx[b] !== tb_code(u_if.payload[4*b +: 4])) begin
                errors++; $display("FAIL rst_byte%0d got %h want %h", b, rx[b], tb_code(u_if.payload[4*b +: 4]));
            end
        end
        checks++; if (busy_cnt != 1600) begin errors++; $display("FAIL rst_busy_len got %0d want 1600", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] pl;
        int          tot_done, bad;
        pl = 40'h13579BDF02; tot_done = 0;
        u_if.payload = pl;
        @(negedge clk); u_if.start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            bad = 0;
            if (f == 2) begin
                fork
                    capture();
                    begin repeat (100) @(negedge clk); u_if.start = 1'b0; end
                join
            end else begin
                capture();
            end
            tot_done += done_cnt;
            for (int b = 0; b < 10; b++) if (rx[b] !== tb_code(pl[4*b +: 4])) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame%0d bad bytes %0d want 0", f, bad); end
            checks++; if (busy_cnt != 1600) begin errors++; $display("FAIL b2b_busy_len%0d got %0d want 1600", f, busy_cnt); end
            checks++; if (done_at_end !== 1'b1) begin errors++; $display("FAIL b2b_done_pos%0d got %b want 1", f, done_at_end); end
            if (f < 2) begin
                checks++;
                if (u_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart%0d busy got %b want 1", f, u_if.busy); end
            end else begin
                checks++;
                if (u_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop busy got %b want 0", u_if.busy); end
            end
        end
        checks++; if (tot_done != 3) begin errors++; $display("FAIL b2b_done_total got %0d want 3", tot_done); end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_patterns();
        test_mixed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end
endmodule
